dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Data-memory subsystem sitting directly downstream of the single-cycle processor's data port (data_addr, write_data, mem_write, read_data).
- Stores are posted into a small FIFO store buffer and drained into an internal word RAM, one write at a time, each taking WRITE_LAT cycles. This models a slow memory.
- Loads are served combinationally: from the youngest matching buffered store, otherwise from the RAM.
- A stall output tells the core to hold its current instruction.

Parameters:
- DEPTH, 4: store-buffer entries; power of two, at least 2.
- MEM_WORDS, 64: RAM size in 32-bit words; power of two. AW = clog2(MEM_WORDS).
- WRITE_LAT, 2: cycles per RAM commit; at least 1.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high reset.
- mem_write, input, 1: store request this cycle.
- mem_read, input, 1: load request this cycle.
- data_addr, input, 32: byte address. Word index = data_addr[AW+1:2]; bits [1:0] are ignored.
- write_data, input, 32: store data.
- read_data, output, 32: load data; combinational.
- stall, output, 1: core must hold its instruction; the request is not accepted this cycle.
- buf_count, output, clog2(DEPTH)+1: number of occupied buffer entries.
- drain_busy, output, 1: drain FSM is in the WRITE state.

Behaviour:
- Reset:
  - Synchronous, active-high, on clk: head, tail and count clear to 0; FSM goes to IDLE; drain counter clears to 0.
  - RAM contents are NOT cleared.
  - After reset: buf_count=0, drain_busy=0, stall=0; read_data reflects RAM.
  - Reset mid-drain discards all pending entries; no partial commit occurs.
- Enqueue:
  - At posedge, if mem_write && !stall: push {word index, write_data} at tail; count increments.
  - If full, stall=1 and the store is not accepted. This holds even if a pop happens at the same edge, because stall is decided from the pre-edge count.
- Simultaneous push and pop at one edge: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Drain FSM, states IDLE and WRITE:
  - IDLE: if count != 0, go to WRITE at the next edge with cnt = WRITE_LAT-1.
  - WRITE, cnt != 0: cnt decrements.
  - WRITE, cnt == 0: RAM[head word] <= head data; pop. If entries remain after the pop, stay in WRITE with cnt reloaded to WRITE_LAT-1; otherwise go to IDLE.
- Latency: a store pushed at edge k is committed at edge k+1+WRITE_LAT, provided it is at the head. Back-to-back commits are spaced WRITE_LAT cycles apart.
- Load path (combinational):
  - read_data = data of the youngest valid entry whose word index matches, otherwise RAM[word index].
  - A store being pushed in the same cycle is not visible to the load.
  - read_data is valid whenever mem_read=1 and stall=0; otherwise its value is don't-care.
- stall = (mem_write && full) || (load hazard, see Optional Feature).
- Addresses alias modulo MEM_WORDS, since upper bits are dropped.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: store-to-load forwarding as described under Behaviour; loads never stall.
- Undefined:
  - read_data = RAM[word index] only.
  - stall is additionally asserted while mem_read=1 and any valid entry matches the load's word index.
  - The stall persists until the last matching entry commits. The load completes in the first cycle after that commit, returning the committed value.

Test Plan:
- Forwarding, STORE_FWD_EN defined, WRITE_LAT=2: store addr 100, data 25 at edge 1 -> buf_count=1. Load addr 100 in cycle 2 -> read_data=25 from the buffer. RAM word 25 holds 25 after edge 4, at which point buf_count=0 and drain_busy=0.
- Full buffer, DEPTH=4, WRITE_LAT=4: stores at edges 1-4 to addrs 0,4,8,12 -> buf_count=4 and stall=1 in cycle 5. The fifth store (addr 16) is held. The first commit at edge 6 drops stall; the fifth store is accepted at edge 7. All five words eventually appear in RAM in order.
- Youngest match: store addr 96 data 7, then addr 96 data 9, back-to-back -> load addr 96 returns 9 while both are buffered. Final RAM word 24 holds 9.
- Reset mid-drain: two stores (addr 0 data 1, addr 4 data 2) followed immediately by a 1-cycle reset, before any commit -> buf_count=0 and drain_busy=0 after the reset edge. RAM words 0 and 1 keep their prior values; no later commit occurs.
- No forwarding, STORE_FWD_EN undefined, WRITE_LAT=2: store addr 100 data 25 at edge 1, load addr 100 from cycle 2 -> stall=1 in cycles 2-4. stall=0 in cycle 5 and read_data=25. A load to addr 200 during cycle 2 -> stall=0.
- Aliasing, MEM_WORDS=64: store addr 260 data 0xDEADBEEF; after drain, load addr 4 -> read_data=0xDEADBEEF (word index 65 mod 64 = 1).

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO in front of a slow word RAM, with combinational loads.
// Build option STORE_FWD_EN: loads take data from buffered stores instead of stalling.
module dmem_store_buffer #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 64,
    parameter int WRITE_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_write,
    input  logic                   mem_read,
    input  logic [31:0]            data_addr,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   stall,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic                   drain_busy
);
    // state | meaning
    // IDLE  | nothing being committed; leaves as soon as the buffer holds an entry
    // WRITE | head entry in flight to RAM; cnt counts down to the commit edge

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WRITE_LAT - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [PW-1:0] head, tail, idx;
    logic [PW:0]   count;
    logic [AW-1:0] ent_word [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [31:0]   ram [MEM_WORDS];

    logic [AW-1:0] word;
    logic          full, push, pop, hit, hazard;
    logic [31:0]   hit_data;
    logic          unused_bits;

    assign word        = data_addr[AW+1:2];
    assign unused_bits = ^{data_addr[31:AW+2], data_addr[1:0], mem_read};
    assign full        = (count == FULL_CNT);
    assign pop         = (state == WRITE) && (cnt == '0);
    assign push        = mem_write && !stall;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW + 1)'(i) < count) && (ent_word[idx] == word)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
        end
    end

`ifdef STORE_FWD_EN
    assign read_data = hit ? hit_data : ram[word];
    assign hazard    = 1'b0;
`else
    assign read_data = ram[word];
    assign hazard    = mem_read && hit;
`endif

    assign stall = (mem_write && full) || hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ent_word[tail] <= word;
            ent_data[tail] <= write_data;
        end
    end

    // Reset wins over a commit landing on the same edge, so nothing half-drains.
    always_ff @(posedge clk) begin
        if (!reset && pop) ram[ent_word[head]] <= ent_data[head];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = WRITE;
            WRITE:   if ((cnt == '0) && (count == (PW + 1)'(1))) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (count != '0) cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end else begin
            cnt <= CNT_LOAD;
        end
    end

    always_comb begin
        drain_busy = (state == WRITE);
        buf_count  = count;
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios plus random traffic against a
// commit-schedule model (each store commits at max(push+1+LAT, previous commit+LAT)).
module tb_dmem_store_buffer;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 64;
    localparam int LAT       = 2;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, mem_write, mem_read;
    logic [31:0] data_addr, write_data, read_data;
    logic        stall, drain_busy;
    logic [2:0]  buf_count;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .WRITE_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .data_addr(data_addr), .write_data(write_data), .read_data(read_data),
        .stall(stall), .buf_count(buf_count), .drain_busy(drain_busy)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          word;
        logic [31:0] data;
        int          commit;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] mem_m [MEM_WORDS];
    bit          known [MEM_WORDS];
    int          e = 0;
    int          last_commit = 0;

    int          exp_count;
    bit          exp_busy, exp_stall, exp_rd_valid;
    logic [31:0] exp_rd;

    function automatic int word_of(logic [31:0] a);
        return int'((a >> 2) % 32'(MEM_WORDS));
    endfunction

    task automatic model_eval();
        int          w;
        bit          hit;
        logic [31:0] hd;
        w   = word_of(data_addr);
        hit = 1'b0;
        hd  = '0;
        foreach (pend[i]) if (pend[i].word == w) begin hit = 1'b1; hd = pend[i].data; end
        exp_count = pend.size();
        exp_busy  = (pend.size() != 0) && (pend[0].commit - LAT <= e);
        exp_stall = (mem_write && pend.size() == DEPTH) || (!FWD && mem_read && hit);
        if (FWD && hit) begin
            exp_rd       = hd;
            exp_rd_valid = mem_read && !exp_stall;
        end else begin
            exp_rd       = mem_m[w];
            exp_rd_valid = mem_read && !exp_stall && known[w];
        end
    endtask

    task automatic drive(bit rst, bit w, bit r, logic [31:0] a, logic [31:0] d);
        reset      = rst;
        mem_write  = w;
        mem_read   = r;
        data_addr  = a;
        write_data = d;
        model_eval();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            pend.delete();
            last_commit = 0;
        end else if (mem_write && !exp_stall) begin
            int c;
            c = e + 2 + LAT;
            if (last_commit + LAT > c) c = last_commit + LAT;
            pend.push_back('{word_of(data_addr), write_data, c});
            last_commit = c;
        end
        e++;
        if (!reset) begin
            while (pend.size() != 0 && pend[0].commit <= e) begin
                mem_m[pend[0].word] = pend[0].data;
                known[pend[0].word] = 1'b1;
                void'(pend.pop_front());
            end
        end
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 32'h0, 32'h0);
            tick();
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 32'h0, 32'h0);
        tick();
        drive(0, 1, 0, 32'h0, 32'h0);
        checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", buf_count); end
        checks++; if (drain_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", drain_busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        drive(0, 0, 0, 32'h0, 32'h0);
    endtask

    // Stores each address in turn, holding it while stalled; checks stall and count every cycle.
    task automatic store_seq(input logic [31:0] addrs[$], input logic [31:0] datas[$]);
        foreach (addrs[i]) begin
            bit done;
            int tries;
            done  = 1'b0;
            tries = 0;
            while (!done && tries < 16) begin
                drive(0, 1, 0, addrs[i], datas[i]);
                checks++; if (stall !== exp_stall) begin errors++; $display("FAIL st_stall: got %0b expected %0b", stall, exp_stall); end
                checks++; if (buf_count !== 3'(exp_count)) begin errors++; $display("FAIL st_count: got %0d expected %0d", buf_count, exp_count); end
                done = !exp_stall;
                tick();
                tries++;
            end
            checks++; if (!done) begin errors++; $display("FAIL st_accept: store %0d never accepted, got stall expected accept", i); end
        end
    endtask

    task automatic test_prefill();
        logic [31:0] a[$], d[$];
        for (int w = 0; w < MEM_WORDS; w++) begin
            a.push_back(32'(w * 4));
            d.push_back(32'h1000_0000 + 32'(w * 17));
        end
        store_seq(a, d);
        idle(DEPTH * LAT + 4);
        checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL pre_drained: got %0d expected 0", buf_count); end
        for (int w = 0; w < MEM_WORDS; w++) begin
            drive(0, 0, 1, 32'(w * 4) + 32'($urandom_range(0, 3)), 32'h0);
            checks++; if (read_data !== 32'h1000_0000 + 32'(w * 17)) begin
                errors++; $display("FAIL pre_ram[%0d]: got %08h expected %08h", w, read_data, 32'h1000_0000 + 32'(w * 17));
            end
        end
    endtask

    task automatic test_forward();
        drive(0, 1, 0, 32'd100, 32'd25);
        tick();
        drive(0, 0, 1, 32'd200, 32'h0);
        checks++; if (buf_count !== 3'd1) begin errors++; $display("FAIL fw_count: got %0d expected 1", buf_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fw_other_stall: got %0b expected 0", stall); end
        checks++; if (read_data !== exp_rd) begin errors++; $display("FAIL fw_other_rd: got %08h expected %08h", read_data, exp_rd); end
        drive(0, 0, 1, 32'd100, 32'h0);
        checks++; if (stall !== !FWD) begin errors++; $display("FAIL fw_stall_c2: got %0b expected %0b", stall, !FWD); end
        if (FWD) begin
            checks++; if (read_data !== 32'd25) begin errors++; $display("FAIL fw_rd_c2: got %0d expected 25", read_data); end
        end
        tick();
        for (int c = 3; c <= 4; c++) begin
            drive(0, 0, 1, 32'd100, 32'h0);
            checks++; if (stall !== !FWD) begin errors++; $display("FAIL fw_stall_c%0d: got %0b expected %0b", c, stall, !FWD); end
            checks++; if (drain_busy !== exp_busy) begin errors++; $display("FAIL fw_busy_c%0d: got %0b expected %0b", c, drain_busy, exp_busy); end
            tick();
        end
        drive(0, 0, 1, 32'd100, 32'h0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fw_stall_c5: got %0b expected 0", stall); end
        checks++; if (read_data !== 32'd25) begin errors++; $display("FAIL fw_rd_c5: got %0d expected 25", read_data); end
        checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL fw_count_c5: got %0d expected 0", buf_count); end
        checks++; if (drain_busy !== 1'b0) begin errors++; $display("FAIL fw_busy_c5: got %0b expected 0", drain_busy); end
    endtask

    task automatic test_youngest();
        drive(0, 1, 0, 32'd96, 32'd7);
        tick();
        drive(0, 1, 0, 32'd96, 32'd9);
        tick();
        drive(0, 0, 1, 32'd97, 32'h0);
        checks++; if (buf_count !== 3'd2) begin errors++; $display("FAIL yg_count: got %0d expected 2", buf_count); end
        checks++; if (stall !== !FWD) begin errors++; $display("FAIL yg_stall: got %0b expected %0b", stall, !FWD); end
        if (FWD) begin
            checks++; if (read_data !== 32'd9) begin errors++; $display("FAIL yg_fwd: got %0d expected 9", read_data); end
        end
        idle(DEPTH * LAT + 4);
        drive(0, 0, 1, 32'd96, 32'h0);
        checks++; if (read_data !== 32'd9) begin errors++; $display("FAIL yg_ram: got %0d expected 9", read_data); end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] a[$], d[$];
        a = '{32'd0, 32'd4};
        d = '{32'h1111_1111, 32'h2222_2222};
        store_seq(a, d);
        idle(DEPTH * LAT + 4);
        drive(0, 1, 0, 32'd0, 32'd1);
        tick();
        drive(0, 1, 0, 32'd4, 32'd2);
        tick();
        drive(1, 0, 0, 32'd0, 32'h0);
        tick();
        drive(0, 0, 0, 32'd0, 32'h0);
        checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL rmd_count: got %0d expected 0", buf_count); end
        checks++; if (drain_busy !== 1'b0) begin errors++; $display("FAIL rmd_busy: got %0b expected 0", drain_busy); end
        idle(10);
        drive(0, 0, 1, 32'd0, 32'h0);
        checks++; if (read_data !== 32'h1111_1111) begin errors++; $display("FAIL rmd_w0: got %08h expected 11111111", read_data); end
        drive(0, 0, 1, 32'd4, 32'h0);
        checks++; if (read_data !== 32'h2222_2222) begin errors++; $display("FAIL rmd_w1: got %08h expected 22222222", read_data); end
    endtask

    task automatic test_full();
        logic [31:0] a[$], d[$];
        for (int i = 0; i < 7; i++) begin
            a.push_back(32'(i * 4));
            d.push_back(32'h5000_0000 + 32'(i));
        end
        store_seq(a, d);
        idle(DEPTH * LAT + 4);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 32'(i * 4), 32'h0);
            checks++; if (read_data !== 32'h5000_0000 + 32'(i)) begin
                errors++; $display("FAIL full_ram[%0d]: got %08h expected %08h", i, read_data, 32'h5000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_alias();
        drive(0, 1, 0, 32'd260, 32'hDEAD_BEEF);
        tick();
        idle(DEPTH * LAT + 4);
        drive(0, 0, 1, 32'd4, 32'h0);
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alias_rd: got %08h expected deadbeef", read_data); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alias_stall: got %0b expected 0", stall); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 99);
            a  = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3) * 256 + $urandom_range(0, 3));
            if (op < 2)       drive(1, 0, 0, a, $urandom);
            else if (op < 45) drive(0, 1, 0, a, $urandom);
            else if (op < 88) drive(0, 0, 1, a, 32'h0);
            else              drive(0, 0, 0, a, 32'h0);
            checks++; if (buf_count !== 3'(exp_count)) begin errors++; $display("FAIL rnd_count@%0d: got %0d expected %0d", n, buf_count, exp_count); end
            checks++; if (drain_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %0b expected %0b", n, drain_busy, exp_busy); end
            checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %0b expected %0b", n, stall, exp_stall); end
            if (exp_rd_valid) begin
                checks++; if (read_data !== exp_rd) begin errors++; $display("FAIL rnd_rd@%0d: got %08h expected %08h", n, read_data, exp_rd); end
            end
            tick();
        end
    endtask

    initial begin
        foreach (known[i]) begin
            known[i] = 1'b0;
            mem_m[i] = '0;
        end
        drive(1, 0, 0, 32'h0, 32'h0);
        test_reset();
        test_prefill();
        test_forward();
        test_youngest();
        test_reset_mid_drain();
        test_full();
        test_alias();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
